// File: rtl/ap_ctrl_hs_driver.sv
// ap_ctrl_hs_driver: issues programmed ap_ctrl_hs transactions to an HLS kernel and reports latency stats.
// Rev 1.0
`default_nettype none

module ap_ctrl_hs_driver #(
    parameter int CNT_W = 32,
    parameter int DEPTH = 4
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             cfg_start,
    input  logic [CNT_W-1:0] cfg_num_txn,
    input  logic [15:0]      cfg_gap,
    input  logic [CNT_W-1:0] cfg_timeout,
    output logic             dut_ap_start,
    input  logic             dut_ap_ready,
    input  logic             dut_ap_done,
    output logic             busy,
    output logic             finish,
    output logic [CNT_W-1:0] txn_issued,
    output logic [CNT_W-1:0] txn_done,
    output logic [CNT_W-1:0] last_latency,
    output logic [CNT_W-1:0] max_latency,
    output logic [CNT_W-1:0] total_cycles,
    output logic             err_protocol,
    output logic             err_timeout
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_GAP    = 3'd2,
        S_DRAIN  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] num_txn;
    logic [CNT_W-1:0] timeout;
    logic [15:0]      gap;
    logic [15:0]      gap_cnt;
    logic [CNT_W-1:0] now;
    logic [CNT_W-1:0] start_ts;
    logic             ts_held;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] ts_fifo [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;

    logic             start_accept;
    logic             handshake;
    logic             pop;
    logic             last_issue;
    logic             abort;
    logic [CNT_W-1:0] cur_ts;
    logic [CNT_W-1:0] pop_latency;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign busy         = (state == S_ISSUE) || (state == S_GAP) || (state == S_DRAIN);
    assign finish       = (state == S_FINISH);
    assign dut_ap_start = (state == S_ISSUE) && (occ != OCC_FULL);

    assign start_accept = cfg_start && ((state == S_IDLE) || (state == S_FINISH));
    assign handshake    = dut_ap_start && dut_ap_ready;
    assign pop          = dut_ap_done && (occ != '0);
    assign last_issue   = ((txn_issued + CNT_W'(1)) == num_txn);
    // Timestamp of the current transaction is the first cycle its ap_start was seen high.
    assign cur_ts       = ts_held ? start_ts : now;
    assign pop_latency  = now - ts_fifo[rd_ptr];
    assign abort        = (occ != '0) && (timeout != '0) && !dut_ap_done
                          && ((idle_cnt + CNT_W'(1)) == timeout);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state        <= S_IDLE;
            num_txn      <= '0;
            timeout      <= '0;
            gap          <= '0;
            gap_cnt      <= '0;
            now          <= '0;
            start_ts     <= '0;
            ts_held      <= 1'b0;
            idle_cnt     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occ          <= '0;
            txn_issued   <= '0;
            txn_done     <= '0;
            last_latency <= '0;
            max_latency  <= '0;
            total_cycles <= '0;
            err_protocol <= 1'b0;
            err_timeout  <= 1'b0;
        end else if (start_accept) begin
            num_txn      <= cfg_num_txn;
            timeout      <= cfg_timeout;
            gap          <= cfg_gap;
            gap_cnt      <= '0;
            now          <= '0;
            start_ts     <= '0;
            ts_held      <= 1'b0;
            idle_cnt     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occ          <= '0;
            txn_issued   <= '0;
            txn_done     <= '0;
            last_latency <= '0;
            max_latency  <= '0;
            total_cycles <= '0;
            err_protocol <= 1'b0;
            err_timeout  <= 1'b0;
            state        <= (cfg_num_txn == '0) ? S_FINISH : S_ISSUE;
        end else begin
            if (busy) begin
                now <= now + CNT_W'(1);
            end

            if (handshake) begin
                ts_fifo[wr_ptr] <= cur_ts;
                wr_ptr          <= ptr_inc(wr_ptr);
                txn_issued      <= txn_issued + CNT_W'(1);
                ts_held         <= 1'b0;
            end else if (dut_ap_start) begin
                start_ts <= cur_ts;
                ts_held  <= 1'b1;
            end

            if (pop) begin
                rd_ptr       <= ptr_inc(rd_ptr);
                txn_done     <= txn_done + CNT_W'(1);
                last_latency <= pop_latency;
                if (pop_latency > max_latency) begin
                    max_latency <= pop_latency;
                end
            end else if (dut_ap_done) begin
                err_protocol <= 1'b1;
            end

            case ({handshake, pop})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase

            if (dut_ap_done || (handshake && (occ == '0))) begin
                idle_cnt <= '0;
            end else if (occ != '0) begin
                idle_cnt <= idle_cnt + CNT_W'(1);
            end

            case (state)
                S_ISSUE: begin
                    if (handshake) begin
                        if (last_issue) begin
                            state <= S_DRAIN;
                        end else if (gap != '0) begin
                            state   <= S_GAP;
                            gap_cnt <= gap - 16'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= S_ISSUE;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
                S_DRAIN: begin
                    if ((occ == '0) || ((occ == OCC_ONE) && pop)) begin
                        state        <= S_FINISH;
                        total_cycles <= now + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase

            // Abort overrides everything: outstanding entries are discarded.
            if (abort) begin
                state        <= S_FINISH;
                err_timeout  <= 1'b1;
                total_cycles <= now + CNT_W'(1);
                occ          <= '0;
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                ts_held      <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ap_ctrl_hs_driver.sv
// tb_ap_ctrl_hs_driver: scoreboard bench with a kernel responder and a timeline reference model.
// Rev 1.0
`default_nettype none

module tb_ap_ctrl_hs_driver;

    localparam int CNT_W = 32;
    localparam int DEPTH = 4;
    localparam int MAXN  = 16;

    typedef struct {
        int rel;
        int total;
        int issued;
        int done;
        int maxl;
        int errp;
        int errt;
        int hi;
    } fin_t;

    typedef struct {
        int lat;
        int idx;
    } lat_t;

    logic             clk;
    logic             ap_rst_n;
    logic             cfg_start;
    logic [CNT_W-1:0] cfg_num_txn;
    logic [15:0]      cfg_gap;
    logic [CNT_W-1:0] cfg_timeout;
    logic             dut_ap_start;
    logic             dut_ap_ready;
    logic             dut_ap_done;
    logic             busy;
    logic             finish;
    logic [CNT_W-1:0] txn_issued;
    logic [CNT_W-1:0] txn_done;
    logic [CNT_W-1:0] last_latency;
    logic [CNT_W-1:0] max_latency;
    logic [CNT_W-1:0] total_cycles;
    logic             err_protocol;
    logic             err_timeout;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   run_base = 0;
    int   spur_cyc = -1;
    int   r_dly [MAXN];
    int   d_dly [MAXN];
    int   exp_hs[$];
    lat_t exp_lat[$];
    fin_t exp_fin[$];

    ap_ctrl_hs_driver #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .ap_clk       (clk),
        .ap_rst_n     (ap_rst_n),
        .cfg_start    (cfg_start),
        .cfg_num_txn  (cfg_num_txn),
        .cfg_gap      (cfg_gap),
        .cfg_timeout  (cfg_timeout),
        .dut_ap_start (dut_ap_start),
        .dut_ap_ready (dut_ap_ready),
        .dut_ap_done  (dut_ap_done),
        .busy         (busy),
        .finish       (finish),
        .txn_issued   (txn_issued),
        .txn_done     (txn_done),
        .last_latency (last_latency),
        .max_latency  (max_latency),
        .total_cycles (total_cycles),
        .err_protocol (err_protocol),
        .err_timeout  (err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Kernel: ready after r_dly cycles of ap_start, in-order done d_dly cycles after handshake.
    initial begin : kernel
        int k;
        int wait_c;
        int last_d;
        int d;
        bit in_txn;
        int due[$];
        dut_ap_ready = 1'b0;
        dut_ap_done  = 1'b0;
        k = 0; wait_c = 0; last_d = -1; in_txn = 1'b0;
        forever begin
            @(negedge clk); #2;
            if (!ap_rst_n) begin
                dut_ap_ready = 1'b0;
                dut_ap_done  = 1'b0;
                due.delete();
                k = 0; in_txn = 1'b0; last_d = -1;
            end else begin
                if (cfg_start && !busy) begin
                    due.delete();
                    k = 0; in_txn = 1'b0; last_d = -1;
                end
                dut_ap_done = ((due.size() > 0) && (due[0] == cyc)) || (cyc == spur_cyc);
                if ((due.size() > 0) && (due[0] == cyc)) void'(due.pop_front());
                if (dut_ap_start && (k < MAXN)) begin
                    if (!in_txn) begin
                        in_txn = 1'b1;
                        wait_c = 0;
                    end
                    if (wait_c >= r_dly[k]) begin
                        dut_ap_ready = 1'b1;
                        if (d_dly[k] >= 0) begin
                            d = cyc + d_dly[k];
                            if (d <= last_d) d = last_d + 1;
                            due.push_back(d);
                            last_d = d;
                        end
                        k++;
                        in_txn = 1'b0;
                    end else begin
                        dut_ap_ready = 1'b0;
                        wait_c++;
                    end
                end else begin
                    dut_ap_ready = 1'b0;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT shows a handshake, a retirement or a finish.
    initial begin : monitor
        logic [CNT_W-1:0] prev_done;
        logic             prev_fin;
        logic             prev_acc;
        int               hi_cnt;
        fin_t             f;
        lat_t             e;
        prev_done = '0; prev_fin = 1'b0; prev_acc = 1'b0; hi_cnt = 0;
        forever begin
            @(negedge clk); #3;
            if (!ap_rst_n) begin
                prev_done = '0; prev_fin = 1'b0; prev_acc = 1'b0; hi_cnt = 0;
            end else begin
                if (dut_ap_start) hi_cnt++;
                if (dut_ap_start && dut_ap_ready) begin
                    if (exp_hs.size() == 0) check("handshake_expected", 0, 1);
                    else check("handshake_cycle", cyc - run_base, exp_hs.pop_front());
                end
                if ((txn_done != prev_done) && (txn_done != '0)) begin
                    if (exp_lat.size() == 0) begin
                        check("retire_expected", 0, 1);
                    end else begin
                        e = exp_lat.pop_front();
                        check("last_latency", longint'(last_latency), e.lat);
                        check("txn_done_step", longint'(txn_done), e.idx + 1);
                    end
                end
                if (finish && (!prev_fin || prev_acc)) begin
                    if (exp_fin.size() == 0) begin
                        check("finish_expected", 0, 1);
                    end else begin
                        f = exp_fin.pop_front();
                        check("finish_cycle", cyc - run_base, f.rel);
                        check("total_cycles", longint'(total_cycles), f.total);
                        check("txn_issued", longint'(txn_issued), f.issued);
                        check("txn_done", longint'(txn_done), f.done);
                        check("max_latency", longint'(max_latency), f.maxl);
                        check("err_protocol", longint'(err_protocol), f.errp);
                        check("err_timeout", longint'(err_timeout), f.errt);
                        check("start_high_cycles", hi_cnt, f.hi);
                        check("busy_at_finish", longint'(busy), 0);
                    end
                    hi_cnt = 0;
                end
                prev_done = txn_done;
                prev_fin  = finish;
                prev_acc  = cfg_start && !busy;
            end
        end
    end

    // Reference timeline: start, handshake and done cycles relative to the cycle where now = 0.
    task automatic run_txns(input int num, input int gap, input int tmo, input int spur_rel,
                            input bit never_done, input bit poke);
        int   s;
        int   hs_a [MAXN];
        int   d_a  [MAXN];
        int   n;
        fin_t f;
        lat_t l;
        f = '{default: 0};
        for (int i = 0; i < num; i++) begin
            s = (i == 0) ? 0 : hs_a[i-1] + gap + 1;
            if ((i >= DEPTH) && (d_a[i-DEPTH] + 1 > s)) s = d_a[i-DEPTH] + 1;
            hs_a[i] = s + r_dly[i];
            d_a[i]  = hs_a[i] + d_dly[i];
            if ((i > 0) && (d_a[i-1] + 1 > d_a[i])) d_a[i] = d_a[i-1] + 1;
            exp_hs.push_back(hs_a[i]);
            f.hi += r_dly[i] + 1;
            if (!never_done) begin
                l.lat = d_a[i] - s;
                l.idx = i;
                exp_lat.push_back(l);
                if (l.lat > f.maxl) f.maxl = l.lat;
            end
        end
        f.issued = num;
        f.done   = never_done ? 0 : num;
        f.errp   = (spur_rel >= 0) ? 1 : 0;
        f.errt   = never_done ? 1 : 0;
        if (num == 0)        f.rel = 0;
        else if (never_done) f.rel = hs_a[0] + tmo + 1;
        else                 f.rel = d_a[num-1] + 1;
        f.total = f.rel;
        exp_fin.push_back(f);

        @(negedge clk); #1;
        cfg_num_txn = CNT_W'(num);
        cfg_gap     = 16'(gap);
        cfg_timeout = CNT_W'(tmo);
        cfg_start   = 1'b1;
        run_base    = cyc + 1;
        spur_cyc    = (spur_rel >= 0) ? run_base + spur_rel : -1;
        @(negedge clk); #1;
        cfg_start = 1'b0;
        n = 0;
        while ((exp_fin.size() != 0) && (n < 3000)) begin
            if (poke && (n == 3)) begin
                cfg_num_txn = CNT_W'(1);
                cfg_start   = 1'b1;
            end else begin
                cfg_start = 1'b0;
            end
            @(negedge clk); #1;
            n++;
        end
        cfg_start = 1'b0;
        check("run_completed", exp_fin.size(), 0);
        check("leftover_handshakes", exp_hs.size(), 0);
        check("leftover_retires", exp_lat.size(), 0);
        exp_fin.delete();
        exp_hs.delete();
        exp_lat.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic set_delays(input int r, input int d);
        for (int i = 0; i < MAXN; i++) begin
            r_dly[i] = r;
            d_dly[i] = d;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ap_start"}, longint'(dut_ap_start), 0);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_finish"}, longint'(finish), 0);
        check({tag, "_issued"}, longint'(txn_issued), 0);
        check({tag, "_done"}, longint'(txn_done), 0);
        check({tag, "_last_lat"}, longint'(last_latency), 0);
        check({tag, "_max_lat"}, longint'(max_latency), 0);
        check({tag, "_total"}, longint'(total_cycles), 0);
        check({tag, "_err_prot"}, longint'(err_protocol), 0);
        check({tag, "_err_tmo"}, longint'(err_timeout), 0);
    endtask

    initial begin : main
        ap_rst_n    = 1'b0;
        cfg_start   = 1'b0;
        cfg_num_txn = '0;
        cfg_gap     = '0;
        cfg_timeout = '0;
        set_delays(0, 5);
        repeat (3) @(negedge clk);
        #1 ap_rst_n = 1'b1;
        #1 check_all_zero("reset");

        set_delays(0, 5);
        run_txns(3, 0, 0, -1, 1'b0, 1'b0);
        run_txns(3, 2, 0, -1, 1'b0, 1'b0);
        set_delays(0, 20);
        run_txns(6, 0, 0, -1, 1'b0, 1'b0);

        set_delays(0, 2);
        run_txns(2, 10, 0, 5, 1'b0, 1'b0);
        check("err_protocol_held", longint'(err_protocol), 1);
        run_txns(0, 0, 0, -1, 1'b0, 1'b0);

        set_delays(0, -1);
        run_txns(1, 0, 50, -1, 1'b1, 1'b0);

        // Mid-run reset with two transactions outstanding.
        set_delays(0, 30);
        exp_hs.push_back(0);
        exp_hs.push_back(1);
        @(negedge clk); #1;
        cfg_num_txn = CNT_W'(4);
        cfg_gap     = '0;
        cfg_timeout = '0;
        cfg_start   = 1'b1;
        run_base    = cyc + 1;
        spur_cyc    = -1;
        @(negedge clk); #1 cfg_start = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1 ap_rst_n = 1'b0;
        @(negedge clk); #1 ap_rst_n = 1'b1;
        #2 check_all_zero("midrun_reset");
        check("reset_leftover_hs", exp_hs.size(), 0);
        exp_hs.delete();
        exp_lat.delete();
        exp_fin.delete();

        set_delays(1, 3);
        run_txns(1, 0, 0, -1, 1'b0, 1'b0);

        for (int run = 0; run < 10; run++) begin
            int num;
            int gap;
            num = int'($urandom_range(1, 12));
            gap = int'($urandom_range(0, 3));
            for (int i = 0; i < MAXN; i++) begin
                r_dly[i] = int'($urandom_range(0, 3));
                d_dly[i] = int'($urandom_range(1, 25));
            end
            run_txns(num, gap, ($urandom_range(0, 1) == 1) ? 500 : 0, -1, 1'b0,
                     (num >= 5) && ($urandom_range(0, 1) == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
